// File: rtl/draw_scheduler_pkg.sv
// rtl/draw_scheduler_pkg.sv - shared constants, state encoding and pixel helper for draw_scheduler
package draw_scheduler_pkg;

  localparam int GRID_SIZE     = 12;
  localparam int SPACING       = 33;
  localparam int X0            = 214;
  localparam int Y0            = 32;
  localparam int START_TIMEOUT = 16;
  localparam int TMO_W         = $clog2(START_TIMEOUT);

  localparam logic [3:0] GRID_MAX = 4'(GRID_SIZE - 1);

  localparam logic [1:0] COL_OFF      = 2'd0;
  localparam logic [1:0] COL_ON       = 2'd1;
  localparam logic [1:0] COL_CURSOR   = 2'd2;
  localparam logic [1:0] COL_PLAYHEAD = 2'd3;

  localparam logic [1:0] REQ_TOGGLE   = 2'd0;
  localparam logic [1:0] REQ_CURSOR   = 2'd1;
  localparam logic [1:0] REQ_PLAYHEAD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  // 10-bit pixel origin of a grid index; 11*33+214 = 577 still fits.
  function automatic logic [9:0] pix(input logic [3:0] g, input int base);
    return 10'(base) + 10'(g) * 10'(SPACING);
  endfunction

endpackage

// File: rtl/draw_scheduler_arb.sv
// rtl/draw_scheduler_arb.sv - rr_arbiter3: 3-way round-robin arbiter with last-grant pointer
module rr_arbiter3 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       update_i,
  output logic [2:0] grant_o,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  logic [1:0] last_q;
  logic [1:0] order [3];

  always_comb begin
    case (last_q)
      2'd0:    order = '{2'd1, 2'd2, 2'd0};
      2'd1:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    grant_o = '0;
    idx_o   = 2'd0;
    valid_o = 1'b0;
    // Walk lowest priority first so the highest-priority hit overwrites.
    for (int k = 2; k >= 0; k--) begin
      if (req_i[order[k]]) begin
        grant_o = 3'b001 << order[k];
        idx_o   = order[k];
        valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                    last_q <= 2'd2;
    else if (update_i && valid_o) last_q <= idx_o;
  end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - sequences grid-cell draw jobs onto the single vga_display engine
// Optional full-grid clear sweep enabled by DRAW_SCHED_CLEAR_SWEEP_EN.
module draw_scheduler
  import draw_scheduler_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic [2:0]  req,
  input  logic [11:0] req_gx,
  input  logic [11:0] req_gy,
  input  logic [5:0]  req_col,
  output logic [2:0]  ack,
  output logic [9:0]  X,
  output logic [8:0]  Y,
  output logic [1:0]  colour,
  output logic        draw_enable,
  input  logic        drawing,
  output logic        busy,
  output logic        err,
  input  logic        clear_start,
  output logic        clear_busy
);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ack_q, ack_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic [1:0]       col_q, col_d;
  logic             de_q, de_d, err_q, err_d;
  logic             sweep_job_q, sweep_job_d;
  logic [2:0]       arb_grant;
  logic [1:0]       arb_idx;
  logic             arb_valid, arb_update, job_end;
  logic [3:0]       sel_gx, sel_gy, sweep_gx, sweep_gy;
  logic [1:0]       sel_col;
  logic             sweep_pend;

  rr_arbiter3 u_arb (
    .clk_i    (CLOCK_50),
    .rst_i    (Reset),
    .req_i    (req),
    .update_i (arb_update),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  always_comb begin
    sel_gx  = req_gx[11:8];
    sel_gy  = req_gy[11:8];
    sel_col = req_col[5:4];
    case (arb_idx)
      REQ_TOGGLE: begin sel_gx = req_gx[3:0]; sel_gy = req_gy[3:0]; sel_col = req_col[1:0]; end
      REQ_CURSOR: begin sel_gx = req_gx[7:4]; sel_gy = req_gy[7:4]; sel_col = req_col[3:2]; end
      default:    ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    de_d        = 1'b0;
    err_d       = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    sweep_job_d = sweep_job_q;
    arb_update  = 1'b0;
    job_end     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Engine may still be busy after a reset mid-draw; never start over it.
        if (!drawing) begin
          if (sweep_pend) begin
            x_d         = pix(sweep_gx, X0);
            y_d         = 9'(pix(sweep_gy, Y0));
            col_d       = COL_OFF;
            de_d        = 1'b1;
            sweep_job_d = 1'b1;
            state_d     = ST_ISSUE;
          end else if (arb_valid) begin
            arb_update  = 1'b1;
            sweep_job_d = 1'b0;
            ack_d       = arb_grant;
            state_d     = ST_ISSUE;
            if (sel_gx > GRID_MAX || sel_gy > GRID_MAX) begin
              err_d = 1'b1;
            end else begin
              de_d  = 1'b1;
              x_d   = pix(sel_gx, X0);
              y_d   = 9'(pix(sel_gy, Y0));
              col_d = sel_col;
            end
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = de_q ? ST_WAIT_START : ST_IDLE;
      end
      ST_WAIT_START: begin
        if (drawing) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == TMO_W'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          job_end = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!drawing) begin
          job_end = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ack_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
      de_q        <= 1'b0;
      err_q       <= 1'b0;
      sweep_job_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      de_q        <= de_d;
      err_q       <= err_d;
      sweep_job_q <= sweep_job_d;
    end
  end

`ifdef DRAW_SCHED_CLEAR_SWEEP_EN
  logic       clear_pend_q, clear_pend_d;
  logic [3:0] sx_q, sx_d, sy_q, sy_d;

  always_comb begin
    clear_pend_d = clear_pend_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    if (clear_start && !clear_pend_q) clear_pend_d = 1'b1;
    // Timeouts also end a sweep job, so a dead cell never stalls the sweep.
    if (job_end && sweep_job_q) begin
      if (sx_q == GRID_MAX) begin
        sx_d = '0;
        if (sy_q == GRID_MAX) begin
          sy_d         = '0;
          clear_pend_d = 1'b0;
        end else begin
          sy_d = sy_q + 4'd1;
        end
      end else begin
        sx_d = sx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      clear_pend_q <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
    end else begin
      clear_pend_q <= clear_pend_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
    end
  end

  assign sweep_pend = clear_pend_q;
  assign sweep_gx   = sx_q;
  assign sweep_gy   = sy_q;
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign sweep_pend = 1'b0;
  assign sweep_gx   = 4'd0;
  assign sweep_gy   = 4'd0;
`endif

  assign ack         = ack_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign colour      = col_q;
  assign draw_enable = de_q;
  assign err         = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign clear_busy  = sweep_pend;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - directed self-checking bench for draw_scheduler
module tb_draw_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic [2:0]  req;
  logic [11:0] req_gx, req_gy;
  logic [5:0]  req_col;
  logic [2:0]  ack;
  logic [9:0]  X;
  logic [8:0]  Y;
  logic [1:0]  colour;
  logic        draw_enable, drawing, busy, err, clear_start, clear_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Engine model: drawing rises eng_delay+1 cycles after draw_enable, stays high eng_hold cycles.
  logic eng_en = 1'b0;
  int   eng_delay = 1;
  int   eng_hold = 40;
  logic eng_drawing = 1'b0;
  int   eng_d = 0;
  int   eng_h = 0;

  assign drawing = eng_drawing;

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (!eng_en) begin
      eng_drawing <= 1'b0;
      eng_d       <= 0;
      eng_h       <= 0;
    end else if (draw_enable) begin
      eng_d <= eng_delay;
    end else if (eng_d != 0) begin
      eng_d <= eng_d - 1;
      if (eng_d == 1) begin
        eng_drawing <= 1'b1;
        eng_h       <= eng_hold;
      end
    end else if (eng_h != 0) begin
      eng_h <= eng_h - 1;
      if (eng_h == 1) eng_drawing <= 1'b0;
    end
  end

  draw_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .Reset       (Reset),
    .req         (req),
    .req_gx      (req_gx),
    .req_gy      (req_gy),
    .req_col     (req_col),
    .ack         (ack),
    .X           (X),
    .Y           (Y),
    .colour      (colour),
    .draw_enable (draw_enable),
    .drawing     (drawing),
    .busy        (busy),
    .err         (err),
    .clear_start (clear_start),
    .clear_busy  (clear_busy)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy !== 1'b0 || drawing !== 1'b0) && t < 500) begin
      tick();
      t++;
    end
    n_cmp++; if (busy !== 1'b0 || drawing !== 1'b0) begin n_bad++; $display("FAIL %s_idle: busy=%b drawing=%b exp 0/0", tag, busy, drawing); end
  endtask

  task automatic test_reset();
    Reset = 1'b1; req = '0; req_gx = '0; req_gy = '0; req_col = '0; clear_start = 1'b0;
    tick(); tick();
    n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL rst_ack: got %b exp 000", ack); end
    n_cmp++; if (X !== 10'd0) begin n_bad++; $display("FAIL rst_x: got %0d exp 0", X); end
    n_cmp++; if (Y !== 9'd0) begin n_bad++; $display("FAIL rst_y: got %0d exp 0", Y); end
    n_cmp++; if (colour !== 2'd0) begin n_bad++; $display("FAIL rst_colour: got %0d exp 0", colour); end
    n_cmp++; if (draw_enable !== 1'b0) begin n_bad++; $display("FAIL rst_de: got %b exp 0", draw_enable); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b exp 0", err); end
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL rst_clear_busy: got %b exp 0", clear_busy); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    int t = 0;
    eng_en = 1'b1; eng_delay = 1; eng_hold = 40;
    req_gx = {4'd0, 4'd0, 4'd3}; req_gy = {4'd0, 4'd0, 4'd2}; req_col = {2'd0, 2'd0, 2'd1};
    req = 3'b001;
    tick();
    n_cmp++; if (ack !== 3'b001) begin n_bad++; $display("FAIL single_ack: got %b exp 001", ack); end
    n_cmp++; if (draw_enable !== 1'b1) begin n_bad++; $display("FAIL single_de: got %b exp 1", draw_enable); end
    n_cmp++; if (X !== 10'd313) begin n_bad++; $display("FAIL single_x: got %0d exp 313", X); end
    n_cmp++; if (Y !== 9'd98) begin n_bad++; $display("FAIL single_y: got %0d exp 98", Y); end
    n_cmp++; if (colour !== 2'd1) begin n_bad++; $display("FAIL single_colour: got %0d exp 1", colour); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b exp 1", busy); end
    req = 3'b000;
    tick();
    n_cmp++; if (draw_enable !== 1'b0 || ack !== 3'b000) begin n_bad++; $display("FAIL single_pulse: de=%b ack=%b exp 0/000", draw_enable, ack); end
    while (drawing !== 1'b1 && t < 20) begin tick(); t++; end
    while (drawing === 1'b1 && t < 100) begin tick(); t++; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_at_fall: got %b exp 1 (t=%0d)", busy, t); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after_fall: got %b exp 0", busy); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_ack;
    logic [9:0] exp_x;
    Reset = 1'b1; tick(); Reset = 1'b0;
    eng_en = 1'b1; eng_delay = 1; eng_hold = 3;
    req_gx = {4'd2, 4'd1, 4'd0}; req_gy = '0; req_col = {2'd3, 2'd2, 2'd1};
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      int t = 0;
      do begin tick(); t++; end while (ack === 3'b000 && t < 100);
      exp_ack = 3'b001 << (g % 3);
      exp_x   = (g % 3 == 0) ? 10'd214 : (g % 3 == 1) ? 10'd247 : 10'd280;
      n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL rr_grant%0d: got %b exp %b", g, ack, exp_ack); end
      n_cmp++; if (X !== exp_x) begin n_bad++; $display("FAIL rr_x%0d: got %0d exp %0d", g, X, exp_x); end
    end
    req = 3'b000;
    wait_idle("rr");
  endtask

  task automatic test_range_error();
    req_gx = {4'd0, 4'd12, 4'd0}; req_gy = '0; req_col = {2'd0, 2'd2, 2'd0};
    req = 3'b010;
    tick();
    n_cmp++; if (ack !== 3'b010) begin n_bad++; $display("FAIL range_ack: got %b exp 010", ack); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL range_err: got %b exp 1", err); end
    n_cmp++; if (draw_enable !== 1'b0) begin n_bad++; $display("FAIL range_de: got %b exp 0", draw_enable); end
    req = 3'b000;
    tick();
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0 || draw_enable !== 1'b0) begin n_bad++; $display("FAIL range_back_idle: busy=%b err=%b de=%b exp 0/0/0", busy, err, draw_enable); end
  endtask

  task automatic test_timeout();
    int early = 0;
    eng_en = 1'b0;
    req_gx = {4'd4, 4'd0, 4'd0}; req_gy = {4'd4, 4'd0, 4'd0}; req_col = {2'd3, 2'd0, 2'd1};
    req = 3'b001;
    tick();
    n_cmp++; if (draw_enable !== 1'b1) begin n_bad++; $display("FAIL tmo_de: got %b exp 1", draw_enable); end
    req = 3'b100;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (err === 1'b1 || ack !== 3'b000) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL tmo_early: got %0d early events exp 0", early); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b exp 1", err); end
    tick();
    n_cmp++; if (ack !== 3'b100) begin n_bad++; $display("FAIL tmo_next_ack: got %b exp 100", ack); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_pulse: got %b exp 0", err); end
    req = 3'b000;
    wait_idle("tmo");
  endtask

  task automatic test_reset_mid_draw();
    int t = 0;
    int bad = 0;
    eng_en = 1'b1; eng_delay = 1; eng_hold = 40;
    req_gx = {4'd0, 4'd2, 4'd1}; req_gy = {4'd0, 4'd2, 4'd1}; req_col = {2'd0, 2'd2, 2'd1};
    req = 3'b001;
    tick();
    req = 3'b000;
    while (drawing !== 1'b1 && t < 20) begin tick(); t++; end
    n_cmp++; if (drawing !== 1'b1) begin n_bad++; $display("FAIL rmd_start: drawing=%b exp 1", drawing); end
    tick(); tick();
    Reset = 1'b1; req = 3'b010;
    tick();
    n_cmp++; if ({busy, X, Y, colour, ack, draw_enable, err} !== 26'd0) begin n_bad++; $display("FAIL rmd_outputs: busy=%b X=%0d Y=%0d col=%0d ack=%b de=%b err=%b exp all 0", busy, X, Y, colour, ack, draw_enable, err); end
    Reset = 1'b0;
    t = 0;
    while (drawing === 1'b1 && t < 100) begin
      tick(); t++;
      if (ack !== 3'b000) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rmd_no_grant: got %0d early acks exp 0", bad); end
    tick();
    n_cmp++; if (ack !== 3'b010) begin n_bad++; $display("FAIL rmd_grant: got %b exp 010", ack); end
    req = 3'b000;
    wait_idle("rmd");
  endtask

`ifdef DRAW_SCHED_CLEAR_SWEEP_EN
  task automatic test_clear_sweep();
    int t = 0;
    int n_draw = 0;
    logic [2:0] got_ack = 3'b000;
    logic [9:0] ex;
    logic [8:0] ey;
    eng_en = 1'b1; eng_delay = 1; eng_hold = 2;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    req_gx = {4'd5, 4'd0, 4'd0}; req_gy = {4'd5, 4'd0, 4'd0}; req_col = {2'd3, 2'd0, 2'd0};
    req = 3'b100;
    n_cmp++; if (clear_busy !== 1'b1) begin n_bad++; $display("FAIL sweep_busy: got %b exp 1", clear_busy); end
    while (got_ack === 3'b000 && t < 3000) begin
      tick(); t++;
      clear_start = 1'b0;
      if (ack !== 3'b000) begin
        got_ack = ack;
      end else if (draw_enable === 1'b1) begin
        ex = 10'(214 + 33 * (n_draw % 12));
        ey = 9'(32 + 33 * (n_draw / 12));
        n_cmp++; if ({X, Y, colour} !== {ex, ey, 2'd0}) begin n_bad++; $display("FAIL sweep_cell%0d: got X=%0d Y=%0d col=%0d exp X=%0d Y=%0d col=0", n_draw, X, Y, colour, ex, ey); end
        n_draw++;
        if (n_draw == 50) clear_start = 1'b1;
      end
    end
    n_cmp++; if (n_draw !== 144) begin n_bad++; $display("FAIL sweep_count: got %0d exp 144", n_draw); end
    n_cmp++; if (got_ack !== 3'b100) begin n_bad++; $display("FAIL sweep_then_ack: got %b exp 100", got_ack); end
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL sweep_busy_end: got %b exp 0", clear_busy); end
    n_cmp++; if (X !== 10'd379 || Y !== 9'd197 || colour !== 2'd3) begin n_bad++; $display("FAIL sweep_ph_job: X=%0d Y=%0d col=%0d exp 379/197/3", X, Y, colour); end
    req = 3'b000;
    wait_idle("sweep");
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n_draw = 0; t = 0;
    while (n_draw < 3 && t < 200) begin tick(); t++; if (draw_enable === 1'b1) n_draw++; end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL sweep_abort: got %b exp 0", clear_busy); end
    n_draw = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (draw_enable === 1'b1) n_draw++; end
    n_cmp++; if (n_draw !== 0) begin n_bad++; $display("FAIL sweep_abort_quiet: got %0d draws exp 0", n_draw); end
  endtask
`else
  task automatic test_clear_sweep();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL noclear_busy: got %b exp 0", clear_busy); end
    req_gx = {4'd5, 4'd0, 4'd0}; req_gy = {4'd5, 4'd0, 4'd0}; req_col = {2'd3, 2'd0, 2'd0};
    req = 3'b100;
    tick();
    n_cmp++; if (ack !== 3'b100) begin n_bad++; $display("FAIL noclear_ack: got %b exp 100", ack); end
    n_cmp++; if (X !== 10'd379 || Y !== 9'd197) begin n_bad++; $display("FAIL noclear_xy: X=%0d Y=%0d exp 379/197", X, Y); end
    req = 3'b000;
    wait_idle("noclear");
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_range_error();
    test_timeout();
    test_reset_mid_draw();
    test_clear_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
